mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It replaces single-cycle decode with a Moore/Mealy state machine that walks each instruction through fetch, decode, execute, memory and writeback. It drives the shared ALU, the single unified memory port and the register-file write enable. It sits beside the existing ALU decoder, immediate decoder and datapath registers: PC, OldPC, IR, A, B, ALUOut and MDR.

---
 rtl/mc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle RV32I control FSM walking each instruction through fetch/decode/execute/memory/writeback.
// Define MC_SEQ_TRAP_EN to park illegal opcodes in a TRAP state with a sticky illegal flag; otherwise they retire as NOPs.
module mc_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [3:0] state,
    output logic       illegal
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRWB   = 4'd12,
        S_LUI      = 4'd13
`ifdef MC_SEQ_TRAP_EN
        , S_TRAP   = 4'd14
`endif
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       pc_we;
        logic       reg_we;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] aop;
        logic [1:0] res;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   mem_done;
    logic   br_taken;

    // Moore outputs of a state; registered one cycle ahead so they are glitch-free.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.src_b = 2'b10; c.res = 2'b10; end
            S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
            S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
            S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.res = 2'b01; c.reg_we = 1'b1; end
            S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
            S_EXECR:    begin c.src_a = 2'b10; c.aop = 2'b10; end
            S_EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.aop = 2'b10; end
            S_ALUWB:    begin c.reg_we = 1'b1; end
            S_BRANCH:   begin c.src_a = 2'b10; c.aop = 2'b01; end
            S_JAL:      begin c.pc_we = 1'b1; c.src_a = 2'b01; c.src_b = 2'b10; end
            S_JALR:     begin c.src_a = 2'b10; c.src_b = 2'b01; c.res = 2'b10; c.pc_we = 1'b1; end
            S_JALRWB:   begin c.src_a = 2'b01; c.src_b = 2'b10; c.res = 2'b10; c.reg_we = 1'b1; end
            S_LUI:      begin c.res = 2'b11; c.reg_we = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // mem_ready only counts while a request is actually being presented.
    assign mem_done = ctrl_q.mem_req & mem_ready;

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = ~lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = ~ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_ALUWB;
`ifdef MC_SEQ_TRAP_EN
                    default:                state_d = S_TRAP;
`else
                    default:                state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_done) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRWB;
`ifdef MC_SEQ_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

`ifdef MC_SEQ_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
`ifdef MC_SEQ_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= decode_ctrl(state_d);
`ifdef MC_SEQ_TRAP_EN
            illegal_q <= illegal_q | (state_d == S_TRAP);
`endif
        end
    end

`ifdef MC_SEQ_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Fetch accept and branch decision are Mealy terms on top of the registered controls.
    assign ir_we      = (state_q == S_FETCH) & mem_done;
    assign pc_we      = ctrl_q.pc_we | ir_we | ((state_q == S_BRANCH) & br_taken);
    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign adr_src    = ctrl_q.adr_src;
    assign reg_we     = ctrl_q.reg_we;
    assign alu_src_a  = ctrl_q.src_a;
    assign alu_src_b  = ctrl_q.src_b;
    assign alu_op     = ctrl_q.aop;
    assign result_src = ctrl_q.res;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: per-instruction step-list model checked every cycle, plus directed literal checks.
// Honours MC_SEQ_TRAP_EN the same way as the design.
module tb_mc_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready;
    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state;
    logic       illegal;

    mc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_we(ir_we),
        .pc_we(pc_we), .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_FETCH, S_DEC, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
        S_ALUWB, S_BR, S_JAL, S_JALR, S_JALRWB, S_LUI, S_TRAP
    } step_t;

    step_t      steps[$];
    bit         m_illegal;
    bit         allow_illegal;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] prog_op[$];
    logic [2:0] prog_f3[$];
    logic [6:0] legal[9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [14:0] last_v;
    int         checks = 0;
    int         passes = 0;

    // {illegal, mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, a[1:0], b[1:0], aop[1:0], res[1:0]}
    function automatic logic [14:0] pack_outs();
        return {illegal, mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
                alu_src_a, alu_src_b, alu_op, result_src};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic step_t cur_step();
        return (steps.size() != 0) ? steps[0] : S_FETCH;
    endfunction

    function automatic bit taken(input logic [2:0] f, input bit z, input bit l, input bit lu);
        case (f)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return lu;
            3'b111:  return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic put(inout logic [14:0] v, inout logic [14:0] m, input int lo, input logic [1:0] val);
        v[lo +: 2] = val;
        m[lo +: 2] = 2'b11;
    endtask

    // Expected outputs of one step: enables always checked, selects only where they matter.
    task automatic expect_for(input step_t s, output logic [14:0] v, output logic [14:0] m);
        v = '0;
        m = 15'h3700;
        case (s)
            S_FETCH: begin
                v[13] = 1'b1; m[11] = 1'b1;
                put(v, m, 6, 2'b00); put(v, m, 4, 2'b10); put(v, m, 2, 2'b00); put(v, m, 0, 2'b10);
                if (mem_ready) begin v[10] = 1'b1; v[9] = 1'b1; end
            end
            S_DEC:    begin put(v, m, 6, 2'b01); put(v, m, 4, 2'b01); put(v, m, 2, 2'b00); end
            S_MEMADR: begin put(v, m, 6, 2'b10); put(v, m, 4, 2'b01); put(v, m, 2, 2'b00); end
            S_MEMRD:  begin v[13] = 1'b1; v[11] = 1'b1; m[11] = 1'b1; end
            S_MEMWB:  begin put(v, m, 0, 2'b01); v[8] = 1'b1; end
            S_MEMWR:  begin v[13] = 1'b1; v[12] = 1'b1; v[11] = 1'b1; m[11] = 1'b1; end
            S_EXECR:  begin put(v, m, 6, 2'b10); put(v, m, 4, 2'b00); put(v, m, 2, 2'b10); end
            S_EXECI:  begin put(v, m, 6, 2'b10); put(v, m, 4, 2'b01); put(v, m, 2, 2'b10); end
            S_ALUWB:  begin put(v, m, 0, 2'b00); v[8] = 1'b1; end
            S_BR: begin
                put(v, m, 6, 2'b10); put(v, m, 4, 2'b00); put(v, m, 2, 2'b01); put(v, m, 0, 2'b00);
                v[9] = taken(funct3, zero, lt, ltu);
            end
            S_JAL: begin
                put(v, m, 0, 2'b00); put(v, m, 6, 2'b01); put(v, m, 4, 2'b10); put(v, m, 2, 2'b00);
                v[9] = 1'b1;
            end
            S_JALR: begin
                put(v, m, 6, 2'b10); put(v, m, 4, 2'b01); put(v, m, 2, 2'b00); put(v, m, 0, 2'b10);
                v[9] = 1'b1;
            end
            S_JALRWB: begin
                put(v, m, 6, 2'b01); put(v, m, 4, 2'b10); put(v, m, 2, 2'b00); put(v, m, 0, 2'b10);
                v[8] = 1'b1;
            end
            S_LUI:    begin put(v, m, 0, 2'b11); v[8] = 1'b1; end
            default:  v = '0;
        endcase
    endtask

    task automatic build_steps(input logic [6:0] o);
        steps.delete();
        steps.push_back(S_DEC);
        case (o)
            7'h03: begin steps.push_back(S_MEMADR); steps.push_back(S_MEMRD); steps.push_back(S_MEMWB); end
            7'h23: begin steps.push_back(S_MEMADR); steps.push_back(S_MEMWR); end
            7'h33: begin steps.push_back(S_EXECR); steps.push_back(S_ALUWB); end
            7'h13: begin steps.push_back(S_EXECI); steps.push_back(S_ALUWB); end
            7'h63: steps.push_back(S_BR);
            7'h6F: begin steps.push_back(S_JAL); steps.push_back(S_ALUWB); end
            7'h67: begin steps.push_back(S_JALR); steps.push_back(S_JALRWB); end
            7'h37: steps.push_back(S_LUI);
            7'h17: steps.push_back(S_ALUWB);
            default: begin
`ifdef MC_SEQ_TRAP_EN
                steps.push_back(S_TRAP);
`endif
            end
        endcase
    endtask

    task automatic fetch_next();
        if (prog_op.size() != 0) begin
            cur_op = prog_op.pop_front();
            cur_f3 = prog_f3.pop_front();
        end else begin
            cur_op = legal[$urandom_range(0, 8)];
            cur_f3 = 3'($urandom_range(0, 7));
            if (allow_illegal && $urandom_range(0, 15) == 0) cur_op = 7'h7F;
        end
        build_steps(cur_op);
    endtask

    task automatic compare();
        logic [14:0] act, ev, m;
        step_t s;
        s = cur_step();
        if (s == S_TRAP) m_illegal = 1'b1;
        expect_for(s, ev, m);
        ev[14] = m_illegal;
        m[14]  = 1'b1;
        act    = pack_outs();
        last_v = act;
        checks++;
        if ((act & m) == (ev & m)) passes++;
        else $display("FAIL step %s: got %h, expected %h (mask %h)", s.name(), act, ev, m);
    endtask

    task automatic advance();
        case (cur_step())
            S_FETCH:        if (mem_ready) fetch_next();
            S_MEMRD, S_MEMWR: if (mem_ready) steps.delete(0);
            S_TRAP:         ;
            default:        steps.delete(0);
        endcase
    endtask

    task automatic cycle(input bit rdy, input bit z, input bit l, input bit lu);
        @(negedge clk);
        mem_ready = rdy; zero = z; lt = l; ltu = lu;
        op = cur_op; funct3 = cur_f3;
        #1;
        compare();
        advance();
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, " outputs in reset"}, int'(pack_outs()), 0);
        steps.delete();
        m_illegal = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, " idle before first clk"}, int'(pack_outs()), 0);
    endtask

    task automatic push_instr(input logic [6:0] o, input logic [2:0] f);
        prog_op.push_back(o);
        prog_f3.push_back(f);
    endtask

    initial begin
        logic [4:0] rw, mr;
        logic [2:0] pw;
        logic [3:0] st0;
        int n, held, res, cnt;
        rst_n = 1'b1; op = '0; funct3 = '0; zero = 0; lt = 0; ltu = 0; mem_ready = 0;
        cur_op = '0; cur_f3 = '0; m_illegal = 0; allow_illegal = 0;
        #2;
        reset_now("init");

        // add with zero-wait memory: 4-cycle instruction, reg_we only in cycle 4
        push_instr(7'h33, 3'b000);
        rw = '0; mr = '0;
        for (int i = 0; i < 5; i++) begin
            cycle(i < 4, 0, 0, 0);
            rw[4-i] = last_v[8];
            mr[4-i] = last_v[13];
        end
        chk("add reg_we sequence", int'(rw), int'(5'b00010));
        chk("add mem_req sequence", int'(mr), int'(5'b10001));

        // load 0x00002083 with three wait states in MEMREAD
        push_instr(7'h03, 3'b010);
        n = 0; held = 0; res = -1; st0 = '0;
        for (int i = 0; i < 9; i++) begin
            cycle((i < 3) || (i == 6) || (i == 7), 0, 0, 0);
            if (i >= 3 && i <= 5 && last_v[13] && last_v[11]) held++;
            if (i == 3) st0 = state;
            if (i == 5) chk("load wait state stable", int'(state), int'(st0));
            if (last_v[8]) begin n++; res = int'(last_v[1:0]); end
        end
        chk("load req held in wait", held, 3);
        chk("load reg_we pulses", n, 1);
        chk("load memwb result_src", res, 1);

        // BEQ taken, BNE not taken, funct3=010 never taken (zero=1 throughout)
        push_instr(7'h63, 3'b000);
        push_instr(7'h63, 3'b001);
        push_instr(7'h63, 3'b010);
        pw = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(i < 9, 1, 0, 0);
            if (i == 2) pw[2] = last_v[9];
            if (i == 5) pw[1] = last_v[9];
            if (i == 8) pw[0] = last_v[9];
        end
        chk("branch pc_we beq/bne/010", int'(pw), int'(3'b100));

        // JALR then JALRWB
        push_instr(7'h67, 3'b000);
        for (int i = 0; i < 5; i++) begin
            cycle(i < 4, 0, 0, 0);
            if (i == 2) chk("jalr pc_we,result_src", int'({last_v[9], last_v[1:0]}), int'(3'b110));
            if (i == 3) chk("jalrwb reg_we,a,b", int'({last_v[8], last_v[7:4]}), int'(5'b10110));
        end

        // illegal opcode 0x7F
        push_instr(7'h7F, 3'b000);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
`ifdef MC_SEQ_TRAP_EN
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'($urandom_range(0, 1)), 0, 0, 0);
            if (last_v[14] && !last_v[13]) cnt++;
        end
        chk("trap illegal held, no mem_req", cnt, 20);
        @(negedge clk);
        #3;
        reset_now("after trap");
`else
        cycle(0, 0, 0, 0);
        chk("illegal nop back to fetch {mem_req,illegal}", int'({last_v[13], last_v[14]}), int'(2'b10));
`endif

        // reset asserted while a store waits in MEMWRITE
        push_instr(7'h23, 3'b010);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("memwrite req,we,adr", int'(last_v[13:11]), int'(3'b111));
        #2;
        reset_now("memwrite abort");
        push_instr(7'h33, 3'b000);
        push_instr(7'h33, 3'b000);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(i < 8, 0, 0, 0);
            if (last_v[12]) cnt++;
        end
        chk("no mem_we after abort", cnt, 0);

        // randomized run
`ifndef MC_SEQ_TRAP_EN
        allow_illegal = 1'b1;
`endif
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
